// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command front-end.
//   - ALU func codes as seen on the external 4-bit ALU func port
//   - command op code for the multi-cycle unsigned multiply
//   - controller state encoding
//   - bit positions inside the {overflow, carry, zero, out} flag vector
package alu_pkg;

    localparam logic [2:0] FUNC_ADD = 3'b000;
    localparam logic [2:0] FUNC_SUB = 3'b001;
    localparam logic [2:0] FUNC_NOT = 3'b010;
    localparam logic [2:0] FUNC_AND = 3'b011;
    localparam logic [2:0] FUNC_OR  = 3'b100;
    localparam logic [2:0] FUNC_XOR = 3'b101;
    localparam logic [2:0] FUNC_LT  = 3'b110;
    localparam logic [2:0] FUNC_EQ  = 3'b111;

    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int FLAG_OUT   = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

endpackage

// File: rtl/alu_mul_step.sv
// alu_mul_step: combinational part of one shift-add multiply iteration.
// The partial product {p_hi, p_lo} starts as {0, multiplier}. Each step
// adds the multiplicand into p_hi (via the external ALU) when the current
// multiplier LSB p_lo[0] is set, then shifts the whole 2W+1-bit sum right.
// Ports:
//   p_hi, p_lo   in  W  current partial product halves
//   mcand        in  W  multiplicand
//   alu_result   in  W  ALU sum p_hi + step_b
//   alu_carry    in  1  ALU carry-out of that sum
//   step_b       out W  addend to present on ALU B (mcand or 0)
//   next_hi      out W  next upper half
//   next_lo      out W  next lower half
module alu_mul_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] p_hi,
    input  logic [W-1:0] p_lo,
    input  logic [W-1:0] mcand,
    input  logic [W-1:0] alu_result,
    input  logic         alu_carry,
    output logic [W-1:0] step_b,
    output logic [W-1:0] next_hi,
    output logic [W-1:0] next_lo
);

    // p_hi itself is routed to ALU A by the caller; only B is selected here.
    logic [W-1:0] unused_hi;
    assign unused_hi = p_hi;

    assign step_b = p_lo[0] ? mcand : '0;

    // Carry-out becomes the new MSB; the dropped bit is the consumed multiplier LSB.
    assign {next_hi, next_lo} = {alu_carry, alu_result, p_lo[W-1:1]};

endmodule

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: command front-end for an external combinational 4-bit ALU.
// Accepts one command at a time, drives the ALU operand/func ports from
// registered state, captures the result with masked flags, and returns a
// registered response. Op 1000 runs a W-cycle unsigned shift-add multiply
// through the ALU adder.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The sender holds valid and its payload stable until that edge; ready may
// be asserted without valid and then has no effect. cmd_ready is high only
// in IDLE; rsp_valid is high only in RESP, with payload held until taken.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command channel
//   cmd_op[3:0], cmd_a, cmd_b       0000-0111 ALU func, 1000 MUL, else reserved
//   rsp_valid/rsp_ready             response channel
//   rsp_result[2W-1:0]              zero-extended result or full product
//   rsp_flags[3:0]                  {overflow, carry, zero, out}
//   rsp_err                         reserved op (or MUL when MUL_EN=0)
//   alu_a, alu_b, alu_func          to external ALU
//   alu_result, alu_overflow,
//   alu_carry, alu_zero, alu_out    from external ALU
//   state                           internal FSM state (debug visibility)
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int W      = 4,
    parameter bit MUL_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [3:0]     cmd_op,
    input  logic [W-1:0]   cmd_a,
    input  logic [W-1:0]   cmd_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_result,
    output logic [3:0]     rsp_flags,
    output logic           rsp_err,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [2:0]     alu_func,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_overflow,
    input  logic           alu_carry,
    input  logic           alu_zero,
    input  logic           alu_out
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t        state, state_next;
    logic [2:0]    func_r;
    logic [W-1:0]  a_r;      // operand A, and the multiplicand during MUL
    logic [W-1:0]  p_hi;     // upper product half during MUL
    logic [W-1:0]  p_lo;     // operand B, shifted as the low product half during MUL
    logic [CW-1:0] cnt;

    logic [W-1:0]  step_b, next_hi, next_lo;
    logic [3:0]    single_flags;
    logic          mul_ok;

    // The controller computes zero itself for every op; the ALU zero is unused.
    logic unused_zero;
    assign unused_zero = alu_zero;

    assign mul_ok = MUL_EN && (cmd_op == OP_MUL);

    alu_mul_step #(.W(W)) u_mul_step (
        .p_hi       (p_hi),
        .p_lo       (p_lo),
        .mcand      (a_r),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .step_b     (step_b),
        .next_hi    (next_hi),
        .next_lo    (next_lo)
    );

    // Next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_op[3])  state_next = EXEC;
                    else if (mul_ok) state_next = MUL;
                    else             state_next = RESP;
                end
            end
            EXEC:    state_next = RESP;
            MUL:     if (cnt == CNT_LAST) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Channel and ALU port drive; ALU ports idle at zero outside EXEC/MUL
    always_comb begin
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        alu_a     = '0;
        alu_b     = '0;
        alu_func  = FUNC_ADD;
        case (state)
            EXEC: begin
                alu_a    = a_r;
                alu_b    = p_lo;
                alu_func = func_r;
            end
            MUL: begin
                alu_a    = p_hi;
                alu_b    = step_b;
                alu_func = FUNC_ADD;
            end
            default: ;
        endcase
    end

    // Flag masking for single ops: the ALU leaves carry/overflow/out stale
    // for funcs that do not define them, so only trusted flags pass.
    always_comb begin
        single_flags            = '0;
        single_flags[FLAG_ZERO] = (alu_result == '0);
        if (func_r == FUNC_ADD || func_r == FUNC_SUB) begin
            single_flags[FLAG_OVF]   = alu_overflow;
            single_flags[FLAG_CARRY] = alu_carry;
        end
        if (func_r == FUNC_LT || func_r == FUNC_EQ) begin
            single_flags[FLAG_OUT] = alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            func_r     <= FUNC_ADD;
            a_r        <= '0;
            p_hi       <= '0;
            p_lo       <= '0;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        func_r     <= cmd_op[2:0];
                        a_r        <= cmd_a;
                        p_hi       <= '0;
                        p_lo       <= cmd_b;
                        cnt        <= '0;
                        rsp_result <= '0;
                        rsp_flags  <= '0;
                        rsp_err    <= cmd_op[3] && !mul_ok;
                    end
                end
                EXEC: begin
                    rsp_result <= {{W{1'b0}}, alu_result};
                    rsp_flags  <= single_flags;
                end
                MUL: begin
                    p_hi <= next_hi;
                    p_lo <= next_lo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        rsp_result           <= {next_hi, next_lo};
                        rsp_flags            <= '0;
                        rsp_flags[FLAG_ZERO] <= ({next_hi, next_lo} == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl with a behavioural 4-bit ALU beside the DUT.
// The ALU model drives deliberately stale flags for funcs that do not
// define them so that the controller's masking is observable.
module tb_alu_cmd_ctrl;
    import alu_pkg::*;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [3:0]     cmd_op;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_result;
    logic [3:0]     rsp_flags;
    logic           rsp_err;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_func;
    logic [W-1:0]   alu_result;
    logic           alu_overflow;
    logic           alu_carry;
    logic           alu_zero;
    logic           alu_out;

    int n_vec = 0;
    int n_err = 0;

    // {err, flags[3:0], result[7:0]}
    logic [12:0] exp_q[$];

    alu_cmd_ctrl #(.W(W), .MUL_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_err      (rsp_err),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_func     (alu_func),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .alu_out      (alu_out)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // External ALU model
    always_comb begin
        logic [4:0] s;
        s            = '0;
        alu_result   = '0;
        alu_carry    = 1'b1;   // stale values for funcs that do not define them
        alu_overflow = 1'b1;
        alu_out      = 1'b1;
        case (alu_func)
            3'b000: begin
                s            = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = s[3:0];
                alu_carry    = s[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3]);
            end
            3'b001: begin
                s            = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_result   = s[3:0];
                alu_carry    = s[4];
                alu_overflow = (alu_a[3] != alu_b[3]) && (s[3] != alu_a[3]);
            end
            3'b010: alu_result = ~alu_a;
            3'b011: alu_result = alu_a & alu_b;
            3'b100: alu_result = alu_a | alu_b;
            3'b101: alu_result = alu_a ^ alu_b;
            3'b110: begin
                alu_out    = ($signed(alu_a) < $signed(alu_b));
                alu_result = {3'b000, alu_out};
            end
            default: begin
                alu_out    = (alu_a == alu_b);
                alu_result = {3'b000, alu_out};
            end
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model from the command semantics, using integer arithmetic.
    task automatic model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         output logic [12:0] exp, output int lat);
        int ua, ub, sa, sb, res;
        logic ovf, cy, out, err;
        ua = int'(a); ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        res = 0; ovf = 0; cy = 0; out = 0; err = 0; lat = 2;
        case (op)
            4'd0: begin
                res = (ua + ub) % 16;
                cy  = (ua + ub) > 15;
                ovf = (sa + sb > 7) || (sa + sb < -8);
            end
            4'd1: begin
                res = (ua - ub + 16) % 16;
                cy  = (ua >= ub);
                ovf = (sa - sb > 7) || (sa - sb < -8);
            end
            4'd2: res = 15 - ua;
            4'd3: res = int'(a & b);
            4'd4: res = int'(a | b);
            4'd5: res = int'(a ^ b);
            4'd6: begin res = (sa < sb) ? 1 : 0; out = (res == 1); end
            4'd7: begin res = (ua == ub) ? 1 : 0; out = (res == 1); end
            4'd8: begin res = ua * ub; lat = W + 1; end
            default: begin err = 1; lat = 1; end
        endcase
        exp = {err, ovf, cy, (res == 0) && !err, out, 8'(res)};
    endtask

    // Driver: issue one command, measure latency, check and retire the response.
    task automatic run_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                           input int hold, input bit early);
        logic [12:0] exp;
        int lat, n;
        model(op, a, b, exp, lat);
        exp_q.push_back(exp);
        rsp_ready = early && (hold == 0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom_range(0, 15));
        cmd_a     = 4'($urandom_range(0, 15));
        cmd_b     = 4'($urandom_range(0, 15));
        n = 1;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'(rsp_valid), 32'd1);
            void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        check($sformatf("latency op=%0h", op), 32'(n), 32'(lat));
        check($sformatf("result op=%0h a=%0h b=%0h", op, a, b), 32'(rsp_result), 32'(exp[7:0]));
        check($sformatf("flags op=%0h a=%0h b=%0h", op, a, b), 32'(rsp_flags), 32'(exp[11:8]));
        check($sformatf("err op=%0h", op), 32'(rsp_err), 32'(exp[12]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_stable", 32'({rsp_err, rsp_flags, rsp_result}), 32'(exp));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp", 32'({rsp_err, rsp_flags, rsp_result}), 32'd0);
        check("rst_alu_ports", 32'({alu_a, alu_b, alu_func}), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_cmd(4'b0000, 4'b0111, 4'b0001, 0, 1'b1);
        run_cmd(4'b0001, 4'b0011, 4'b0011, 0, 1'b1);
        run_cmd(4'b0110, 4'b1110, 4'b0001, 0, 1'b0);
        run_cmd(4'b0011, 4'b1100, 4'b1010, 0, 1'b0);
        run_cmd(4'b1000, 4'b1111, 4'b1111, 0, 1'b1);
        run_cmd(4'b1000, 4'b0000, 4'b1011, 0, 1'b0);
        run_cmd(4'b1010, 4'b0101, 4'b0110, 3, 1'b0);

        // Reset in the 2nd MUL cycle
        cmd_valid = 1'b1;
        cmd_op    = OP_MUL;
        cmd_a     = 4'd5;
        cmd_b     = 4'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", 32'(dut.state), 32'(IDLE));
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        check("abort_never_presented", 32'(seen), 32'd0);
        run_cmd(4'b0000, 4'b0010, 4'b0010, 0, 1'b0);

        // Randomized commands
        for (int k = 0; k < 60; k++) begin
            logic [3:0] op;
            if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(9, 15));
            else                           op = 4'($urandom_range(0, 8));
            run_cmd(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Sequential command front-end that sits on the operand side of the combinational 4-bit ALU (func codes 000–111).
- Accepts commands over a valid/ready channel, drives the ALU operand/func ports from registers, and captures the ALU result and flags.
- Returns a masked, registered response over a second valid/ready channel.
- Adds one multi-cycle op, unsigned MUL, built from repeated ALU add steps using the ALU carry-out.

Parameters:
- W, 4, datapath width. Must equal the ALU width; only 4 is supported.
- MUL_EN, 1, when 0 op 1000 is treated as reserved.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  4  0000–0111 = ALU func passthrough; 1000 = MUL; 1001–1111 reserved
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  2W  result; zero-extended for single ops, full product for MUL
- rsp_flags  out  4  {overflow, carry, zero, out}
- rsp_err  out  1  reserved op, or MUL with MUL_EN=0
- alu_a  out  W  to ALU A
- alu_b  out  W  to ALU B
- alu_func  out  3  to ALU func
- alu_result  in  W  from ALU
- alu_overflow  in  1  from ALU
- alu_carry  in  1  from ALU
- alu_zero  in  1  from ALU
- alu_out  in  1  from ALU

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high (rst); all state updates on the rising edge of clk.
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, alu_a=0, alu_b=0, alu_func=000.
- Reset mid-operation aborts any EXEC, MUL or RESP. The pending response is dropped and never presented.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch op, a, b, then:
    - op 0–7 → EXEC.
    - op 1000 with MUL_EN=1 → MUL.
    - otherwise → RESP with rsp_err=1 and result/flags 0.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b come from registers; alu_func = op[2:0].
  - Capture at end of cycle: result = zero-extended alu_result.
  - zero = (alu_result==0), computed locally for all single ops.
  - carry and overflow = ALU values for func 000/001; forced 0 otherwise.
  - out = alu_out for func 110/111; forced 0 otherwise, because the ALU holds a stale out for other funcs.
  - Next state: RESP.
- MUL (exactly W cycles, counter 0..W-1):
  - alu_func=000, alu_a = P_hi, alu_b = multiplicand when P_lo[0]==1, else 0.
  - Each cycle: {P_hi, P_lo} <= {alu_carry, alu_result, P_lo[W-1:1]}.
  - Initial values: P_hi=0, P_lo=multiplier.
  - After the last step: rsp_result = {P_hi, P_lo}; zero = (product==0); carry=overflow=out=0.
  - Operands are treated as unsigned.
- RESP:
  - rsp_valid=1; rsp_result, rsp_flags and rsp_err are held stable until rsp_valid && rsp_ready.
  - On handshake → IDLE.
  - cmd_ready=0 in EXEC, MUL and RESP; there is no command overlap.
- Latency, from the cmd handshake edge to rsp_valid rising:
  - single op: 2 cycles;
  - MUL: W+1 cycles;
  - reserved op: 1 cycle.
- The next command is accepted earliest on the cycle after the rsp handshake.
- cmd_valid while busy is ignored; the upstream holds it.
- rsp_ready asserted while rsp_valid=0 has no effect.
- Arithmetic: all ALU inputs and outputs are W bits. No sign interpretation inside the controller except the passthrough of ALU flags.

Decomposition:
- Shared package alu_pkg:
  - FUNC_ADD=3'b000, FUNC_SUB=3'b001, FUNC_NOT=3'b010, FUNC_AND=3'b011, FUNC_OR=3'b100, FUNC_XOR=3'b101, FUNC_LT=3'b110, FUNC_EQ=3'b111.
  - OP_MUL=4'b1000.
  - State encoding: IDLE/EXEC/MUL/RESP.
  - Flag bit indices.
- One natural sub-module: alu_mul_step, the combinational shift/next-partial computation for one MUL iteration.
- The ALU itself stays external and is instantiated beside this block at the top level.

Test Plan:
- Reset, then op=0000, a=0111, b=0001, rsp_ready=1 → rsp_valid 2 cycles after accept; result=0x08; flags overflow=1, carry=0, zero=0, out=0.
- op=0001, a=0011, b=0011 → result=0x00; zero=1, carry=1, overflow=0.
- op=0110, a=1110 (−2), b=0001 → out=1, carry=0, overflow=0. Then op=0011, a=1100, b=1010 → result=0x08 and out=0; checks stale-flag masking.
- op=1000, a=1111, b=1111 → rsp_valid 5 cycles after accept; result=0xE1; zero=0. Then a=0000, b=1011 → result=0x00, zero=1.
- op=1010 → rsp_err=1, result=0, 1-cycle latency. Hold rsp_ready=0 for 3 cycles → outputs stable and cmd_ready=0 throughout.
- Assert rst in the 2nd MUL cycle → next cycle state IDLE, cmd_ready=1, rsp_valid=0; the aborted response is never presented, and a following ADD 0010+0010 returns 0x04.
